// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : ps2_pkg                                                      |
// | Purpose   : Shared constants, types and helpers for PS/2 key sequencing. |
// |             Prefix bytes, game-key scan codes and indices, decoder state |
// |             encoding, event width and the scan-code lookup function.     |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package ps2_pkg;

   // Prefix bytes
   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   // Game-key scan codes
   localparam logic [7:0] CODE_SPACE = 8'h29;  // non-extended
   localparam logic [7:0] CODE_UP    = 8'h75;  // extended
   localparam logic [7:0] CODE_DOWN  = 8'h72;  // extended
   localparam logic [7:0] CODE_ESC   = 8'h76;  // non-extended

   // Key indices (bit positions in key_down / key_press)
   localparam logic [1:0] KEY_SPACE = 2'd0;
   localparam logic [1:0] KEY_UP    = 2'd1;
   localparam logic [1:0] KEY_DOWN  = 2'd2;
   localparam logic [1:0] KEY_ESC   = 2'd3;

   localparam int NUM_KEYS = 4;

   // Event word: {is_make, key_idx[1:0]}
   localparam int EVT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } dec_state_t;

   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
   } key_lookup_t;

   // Maps (extended flag, scan code) to a game-key index. The extended flag
   // is part of the key: 72h without E0 is keypad 2, not DOWN.
   function automatic key_lookup_t lookup_key(input logic ext, input logic [7:0] code);
      key_lookup_t r;
      r.hit = 1'b0;
      r.idx = 2'd0;
      case ({ext, code})
         {1'b0, CODE_SPACE}: begin r.hit = 1'b1; r.idx = KEY_SPACE; end
         {1'b1, CODE_UP}:    begin r.hit = 1'b1; r.idx = KEY_UP;    end
         {1'b1, CODE_DOWN}:  begin r.hit = 1'b1; r.idx = KEY_DOWN;  end
         {1'b0, CODE_ESC}:   begin r.hit = 1'b1; r.idx = KEY_ESC;   end
         default:            ;
      endcase
      return r;
   endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/evt_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : evt_fifo                                                     |
// | Purpose   : Small synchronous FIFO for key events. Outputs are driven    |
// |             directly from registers (count, storage, read pointer).      |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_i        in   clock                                                |
// |   rst_i        in   synchronous active-high reset                        |
// |   push_i       in   write request (accepted if not full or popping)      |
// |   push_data_i  in   WIDTH  data to write                                 |
// |   pop_i        in   read request (ignored when empty)                    |
// |   full_o       out  FIFO holds DEPTH entries                              |
// |   empty_o      out  FIFO holds no entries                                 |
// |   data_o       out  WIDTH  head entry                                     |
// +--------------------------------------------------------------------------+
module evt_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;

   logic full, empty, do_pop, do_push;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // still accepted when paired with a pop.
   assign do_pop  = pop_i && !empty;
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   assign full_o  = full;
   assign empty_o = empty;
   assign data_o  = mem_q[rd_ptr_q];

endmodule : evt_fifo
`default_nettype wire

// File: rtl/ps2_key_event_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : ps2_key_event_ctrl                                           |
// | Purpose   : Turns the PS/2 scan-code byte stream into held key levels,   |
// |             one-cycle press pulses and a queue of make/break events for  |
// |             four game keys (SPACE, UP, DOWN, ESC).                       |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   CLOCK_50    in   system clock                                          |
// |   reset       in   synchronous active-high reset                         |
// |   code_valid  in   one-cycle byte strobe                                 |
// |   code        in   8  scan-code byte                                     |
// |   code_err    in   framing/parity error on this byte                     |
// |   key_down    out  4  held level {ESC, DOWN, UP, SPACE}                  |
// |   key_press   out  4  one-cycle pulse on released->held                  |
// |   evt_valid   out  event queue non-empty                                 |
// |   evt_data    out  3  head event {is_make, key_idx}                      |
// |   evt_ready   in   consumer pop                                          |
// |   overflow    out  sticky: an event was dropped on a full queue          |
// +--------------------------------------------------------------------------+
module ps2_key_event_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int PREFIX_TIMEOUT = 100000
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                code_valid,
   input  logic [7:0]          code,
   input  logic                code_err,
   output logic [NUM_KEYS-1:0] key_down,
   output logic [NUM_KEYS-1:0] key_press,
   output logic                evt_valid,
   output logic [EVT_W-1:0]    evt_data,
   input  logic                evt_ready,
   output logic                overflow
);

   localparam int TMO_W = $clog2(PREFIX_TIMEOUT + 1);

   dec_state_t          state_q, state_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [NUM_KEYS-1:0] key_down_q, key_down_d;
   logic [NUM_KEYS-1:0] key_press_q, key_press_d;
   logic                overflow_q, overflow_d;

   logic                timeout;
   logic                push;
   logic [EVT_W-1:0]    push_data;
   logic                pop;
   logic                fifo_full, fifo_empty;
   logic [EVT_W-1:0]    fifo_data;
   key_lookup_t         lk;
   logic                is_make;

   assign timeout = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_W'(PREFIX_TIMEOUT));
   assign pop     = !fifo_empty && evt_ready;

   // Extended flag comes from the state that precedes the key byte.
   assign lk      = lookup_key((state_q == ST_EXT) || (state_q == ST_EXT_BRK), code);
   assign is_make = (state_q == ST_IDLE) || (state_q == ST_EXT);

   // ---------------------------------------------------------------------
   // Decoder next-state, key update and event generation
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      key_down_d  = key_down_q;
      key_press_d = '0;
      push        = 1'b0;
      push_data   = '0;

      if (code_valid) begin
         // A byte arriving on the timeout cycle is decoded in the current
         // state, so the timeout check lives in the else branch.
         if (code_err) begin
            state_d = ST_IDLE;
         end else if (code == CODE_EXT) begin
            state_d = ST_EXT;
         end else if (code == CODE_BRK) begin
            case (state_q)
               ST_IDLE: state_d = ST_BRK;
               ST_EXT:  state_d = ST_EXT_BRK;
               default: state_d = ST_IDLE;   // doubled F0: drop sequence
            endcase
         end else begin
            state_d = ST_IDLE;
            if (lk.hit) begin
               if (is_make && !key_down_q[lk.idx]) begin
                  key_down_d[lk.idx]  = 1'b1;
                  key_press_d[lk.idx] = 1'b1;
                  push                = 1'b1;
                  push_data           = {1'b1, lk.idx};
               end else if (!is_make && key_down_q[lk.idx]) begin
                  key_down_d[lk.idx] = 1'b0;
                  push               = 1'b1;
                  push_data          = {1'b0, lk.idx};
               end
            end
         end
      end else if (timeout) begin
         state_d = ST_IDLE;
      end
   end

   // Counter measures silence after a prefix; any byte restarts it.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      if (code_valid || (state_q == ST_IDLE) || timeout) begin
         tmo_cnt_d = '0;
      end
   end

   assign overflow_d = overflow_q || (push && fifo_full && !pop);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tmo_cnt_q   <= '0;
         key_down_q  <= '0;
         key_press_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_cnt_q   <= tmo_cnt_d;
         key_down_q  <= key_down_d;
         key_press_q <= key_press_d;
         overflow_q  <= overflow_d;
      end
   end

   evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk_i       (CLOCK_50),
      .rst_i       (reset),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .data_o      (fifo_data)
   );

   assign key_down  = key_down_q;
   assign key_press = key_press_q;
   assign evt_valid = !fifo_empty;
   assign evt_data  = fifo_data;
   assign overflow  = overflow_q;

endmodule : ps2_key_event_ctrl
`default_nettype wire

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

- Sequences the raw byte stream from the PS/2 receiver into game-level key state.
- Decodes the E0 (extended) and F0 (break) prefix sequences, tracks held state for four game keys, and emits one-cycle press pulses.
- Queues make/break events in a small FIFO for the game FSM.
- Sits between the PS/2 receive front end and the game control logic, replacing ad-hoc single-key latching.

## Interface

Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- PREFIX_TIMEOUT, 100000: cycles allowed between a prefix byte and the next byte (2 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz. Only clock.
- reset  in  1  synchronous, active-high.
- code_valid  in  1  one-cycle strobe; code/code_err are valid this cycle.
- code  in  8  received scan-code byte.
- code_err  in  1  framing/parity error on this byte.
- key_down  out  4  held level per key; bit0 SPACE, bit1 UP, bit2 DOWN, bit3 ESC.
- key_press  out  4  one-cycle pulse on the released→held transition.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  3  {is_make, key_idx[1:0]}; head of FIFO.
- evt_ready  in  1  consumer pop; a pop occurs when evt_valid && evt_ready.
- overflow  out  1  sticky; set when an event is dropped on full. Cleared only by reset.

## Operation

Key map (extended flag, code):
- SPACE (0, 29h) = idx 0
- UP (1, 75h) = idx 1
- DOWN (1, 72h) = idx 2
- ESC (0, 76h) = idx 3

Decoder FSM states and transitions, evaluated only on cycles with code_valid:
- States: IDLE, EXT, BRK, EXT_BRK.
- code_err=1: byte discarded; state → IDLE.
- E0h: state → EXT, from any state.
- F0h: IDLE → BRK; EXT → EXT_BRK; BRK or EXT_BRK → IDLE (malformed; discarded).
- Any other byte: look up (ext = state∈{EXT,EXT_BRK}, code).
  - Make when state∈{IDLE,EXT}; break otherwise.
  - State → IDLE.
  - Unmapped bytes (including E1h) are ignored.

Key state rules:
- Make on a released key: set key_down bit, pulse key_press bit, push event {1,idx}.
- Make on a held key (typematic repeat): no change, no pulse, no event.
- Break on a held key: clear key_down bit, push event {0,idx}.
- Break on a released key: ignored.

Prefix timeout:
- Counter runs while state≠IDLE and resets on every code_valid.
- Reaching PREFIX_TIMEOUT returns the FSM to IDLE; the pending prefix is discarded.
- Counter width is $clog2(PREFIX_TIMEOUT+1).

FIFO:
- Push is accepted if not full, or if a pop occurs in the same cycle.
- Otherwise the event is dropped and overflow ← 1; key_down/key_press still update.
- Pop on empty is a no-op.

## Timing

- Reset values: key_down=0, key_press=0, evt_valid=0, evt_data=0, overflow=0; FSM=IDLE; timeout counter=0; FIFO empty.
- code_valid at cycle N → key_down/key_press updated at N+1.
- Push at N → evt_valid=1 at N+1 if the FIFO was empty.
- key_press is high for exactly one cycle.
- evt_data is stable while evt_valid && !evt_ready.
- Events leave the FIFO in push order.
- Simultaneous push and pop when full: both succeed; count unchanged; no overflow.
- Simultaneous push and pop when empty: push lands; evt_valid=1 next cycle.
- Timeout and code_valid in the same cycle: code_valid wins; the byte is decoded in the current state.
- reset asserted mid-sequence: all state returns to reset values the next cycle; queued events are lost.
- code_valid closer than 1 cycle apart is not possible; back-to-back strobes on consecutive cycles must be handled.

## Structure

- Shared package ps2_pkg holds:
  - prefix constants: E0h, F0h
  - key code constants: 29h, 75h, 72h, 76h
  - key index constants
  - FSM state enum
  - event width constant (3)
- Sub-module evt_fifo: synchronous FIFO, width 3, depth FIFO_DEPTH, registered outputs, full/empty flags.
- Decoder FSM, timeout counter and key registers live in ps2_key_event_ctrl.

## Test plan

- 29h → key_down=0001 and key_press=0001 for 1 cycle; evt_data=100b. Then F0h,29h → key_down=0000; evt_data=000b; no key_press.
- E0h,75h then E0h,75h again (typematic) → one event 101b only; key_down=0010; second make gives no pulse.
- E0h, then silence for PREFIX_TIMEOUT (bench sets 16) cycles, then 72h → key_down unchanged (72h non-extended is unmapped); no event.
- 29h with code_err=1 → no change. Then F0h with code_err, then 29h → make accepted (FSM was back in IDLE).
- FIFO_DEPTH=4, evt_ready=0, alternating make/break SPACE ×6 → 4 events queued, overflow=1, key_down matches last byte. Then drain → events in order 100,000,100,000.
- FIFO full, then push and pop in the same cycle → no overflow, count stays 4. Then assert reset mid-E0 sequence → all outputs 0 next cycle.
